// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, MUL/DIV,
// data-memory wait and branch-redirect sources into per-stage write/bubble controls.
module pipe_stall_ctrl #(
  parameter int unsigned MDU_LAT  = 33,
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_use_hz,
  input  logic       mdu_op_ex,
  input  logic       branch_taken_ex,
  input  logic       mem_req_mem,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_bubble,
  output logic       mem_wb_bubble,
  output logic       mdu_start,
  output logic       mem_timeout,
  output logic [1:0] state
);

  localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  MDU_LOAD = CNT_W'(MDU_LAT - 1);
  localparam logic [WCNT_W-1:0] WMAX     = WCNT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MDU  = 2'd1,
    MEMW = 2'd2
  } state_t;

  state_t              state_q, state_d, cur_st;
  logic [CNT_W-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mdu_done_q, mdu_done_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                run_rules, set_done;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    mdu_start     = 1'b0;
    state_d       = state_q;
    mdu_cnt_d     = mdu_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mdu_done_d    = mdu_done_q;
    mem_timeout_d = mem_timeout_q;
    run_rules     = 1'b0;
    set_done      = 1'b0;

    // While rst is high the outputs follow the RUN rules regardless of state_q.
    cur_st = rst ? RUN : state_q;

    case (cur_st)
      RUN: run_rules = 1'b1;
      MDU: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
        mdu_cnt_d     = mdu_cnt_q - CNT_W'(1);
        // Leaving as the counter hits zero makes the stall exactly MDU_LAT cycles.
        if (mdu_cnt_d == '0) begin
          state_d  = RUN;
          set_done = 1'b1;
        end
      end
      MEMW: begin
        if (!mem_ready) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
          wait_cnt_d    = (wait_cnt_q == WMAX) ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);
          if (wait_cnt_d == WMAX) mem_timeout_d = 1'b1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          run_rules  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_rules) begin
      if (mem_req_mem && !mem_ready) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
        state_d       = MEMW;
        wait_cnt_d    = WCNT_W'(1);
        if (WCNT_W'(1) == WMAX) mem_timeout_d = 1'b1;
      end else if (mdu_op_ex && !mdu_done_q) begin
        mdu_start     = ~rst;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
        mdu_cnt_d     = MDU_LOAD;
        state_d       = MDU;
      end else if (branch_taken_ex) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_hz) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    // mdu_done blocks a restart until the finished MUL/DIV has moved out of EX.
    if (set_done) mdu_done_d = 1'b1;
    else if (ex_mem_write && !ex_mem_bubble) mdu_done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      mdu_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      mdu_done_q    <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mdu_cnt_q     <= mdu_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mdu_done_q    <= mdu_done_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule
